// File: rtl/rvb_bmat_share.sv
// Two-port front end that time-shares one rvb_bmatxor unit: arbitrates BMATOR/BMATXOR
// requests, keeps a single operation in flight and returns the result on the owner's port.
module rvb_bmat_share #(
    parameter int FAIR = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [63:0] req0_rs1,
    input  logic [63:0] req0_rs2,
    input  logic        req0_insn14,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [63:0] req1_rs1,
    input  logic [63:0] req1_rs2,
    input  logic        req1_insn14,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [63:0] rsp0_rd,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [63:0] rsp1_rd,
    output logic        core_din_valid,
    input  logic        core_din_ready,
    output logic [63:0] core_din_rs1,
    output logic [63:0] core_din_rs2,
    output logic        core_din_insn14,
    input  logic        core_dout_valid,
    output logic        core_dout_ready,
    input  logic [63:0] core_dout_rd,
    output logic        busy,
    output logic [15:0] op_count
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]  state;
    logic        owner;
    logic        last;
    logic [63:0] op_rs1;
    logic [63:0] op_rs2;
    logic        op_xor;
    logic [63:0] res;
    logic        grant;
    logic        req_hs;
    logic        rsp_hs;
    logic        idle;

    // Tie-break: round-robin favours the port not served last; fixed priority favours port 0.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = (FAIR != 0) ? ~last : 1'b0;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    assign idle       = (state == S_IDLE) && !reset;
    assign req0_ready = idle && req0_valid && !grant;
    assign req1_ready = idle && req1_valid && grant;
    assign req_hs     = req0_ready || req1_ready;

    assign rsp0_valid = (state == S_RESP) && !owner;
    assign rsp1_valid = (state == S_RESP) && owner;
    assign rsp0_rd    = res;
    assign rsp1_rd    = res;
    assign rsp_hs     = (state == S_RESP) && (owner ? rsp1_ready : rsp0_ready);

    assign core_din_valid  = (state == S_ISSUE);
    assign core_din_rs1    = op_rs1;
    assign core_din_rs2    = op_rs2;
    assign core_din_insn14 = op_xor;
    assign core_dout_ready = (state == S_ISSUE) || (state == S_WAIT);

    assign busy = (state != S_IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            owner    <= 1'b0;
            last     <= 1'b1;
            op_count <= 16'd0;
            res      <= 64'd0;
        end else begin
            op_count <= op_count + {15'd0, rsp_hs};
            case (state)
                S_IDLE: begin
                    if (req_hs) begin
                        owner <= grant;
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // A combinational core may answer in the same cycle it accepts.
                    if (core_din_ready) begin
                        if (core_dout_valid) begin
                            res   <= core_dout_rd;
                            state <= S_RESP;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (core_dout_valid) begin
                        res   <= core_dout_rd;
                        state <= S_RESP;
                    end
                end
                default: begin
                    if (rsp_hs) begin
                        last  <= owner;
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // Operand holding registers carry data only, so they need no reset.
    always_ff @(posedge clock) begin
        if (req_hs) begin
            op_rs1 <= grant ? req1_rs1 : req0_rs1;
            op_rs2 <= grant ? req1_rs2 : req0_rs2;
            op_xor <= grant ? req1_insn14 : req0_insn14;
        end
    end

endmodule

// File: tb/tb_rvb_bmat_share.sv
// Bench for rvb_bmat_share: two instances (round-robin and fixed priority), each with a
// behavioural bit-matrix core, checked every cycle against a transaction-level model.
module tb_rvb_bmat_share;

    logic        clock;
    logic        reset;
    logic        rq_v [2][2];
    logic        rq_r [2][2];
    logic [63:0] rq_a [2][2];
    logic [63:0] rq_b [2][2];
    logic        rq_x [2][2];
    logic        rs_v [2][2];
    logic        rs_r [2][2];
    logic [63:0] rs_d [2][2];
    logic        c_iv [2];
    logic        c_ir [2];
    logic [63:0] c_ia [2];
    logic [63:0] c_ib [2];
    logic        c_ix [2];
    logic        c_ov [2];
    logic        c_or [2];
    logic [63:0] c_od [2];
    logic        busy [2];
    logic [15:0] opc  [2];
    logic        rdy_en [2];

    int          core_cyc;
    int          act;
    bit          chk_lat;
    int          lat_exp;
    int          frc_n;
    int          lit_own_q [$];
    logic [63:0] lit_rd_q [$];
    logic [15:0] lit_opc_q [$];

    int          n_chk;
    int          n_fail;

    // 8x8 GF(2)/Boolean matrix product; 64'h0102040810204080 is the identity for rs2.
    function automatic logic [63:0] bmat(input logic [63:0] a, input logic [63:0] b, input logic x);
        logic [63:0] r;
        logic        acc;
        logic        t;
        r = '0;
        for (int row = 0; row < 8; row++) begin
            for (int col = 0; col < 8; col++) begin
                acc = 1'b0;
                for (int k = 0; k < 8; k++) begin
                    t   = a[8*row+k] & b[8*k+7-col];
                    acc = x ? (acc ^ t) : (acc | t);
                end
                r[8*row+col] = acc;
            end
        end
        return r;
    endfunction

    initial clock = 1'b0;
    always #5 clock = ~clock;

    for (genvar i = 0; i < 2; i++) begin : g_inst
        logic        cbusy;
        logic [3:0]  ccnt;
        logic [63:0] cres;

        always_ff @(posedge clock) begin
            if (reset) begin
                cbusy <= 1'b0;
                ccnt  <= 4'd0;
            end else if (core_cyc != 0 && c_iv[i] && c_ir[i]) begin
                cbusy <= 1'b1;
                ccnt  <= core_cyc[3:0];
                cres  <= bmat(c_ia[i], c_ib[i], c_ix[i]);
            end else if (cbusy && ccnt != 4'd0) begin
                ccnt <= ccnt - 4'd1;
            end else if (cbusy && c_or[i]) begin
                cbusy <= 1'b0;
            end
        end

        assign c_ir[i] = rdy_en[i] && (core_cyc == 0 || !cbusy);
        assign c_ov[i] = (core_cyc == 0) ? (c_iv[i] && c_ir[i]) : (cbusy && ccnt == 4'd0);
        assign c_od[i] = (core_cyc == 0) ? bmat(c_ia[i], c_ib[i], c_ix[i]) : cres;

        rvb_bmat_share #(.FAIR(i == 0 ? 1 : 0)) u_dut (
            .clock          (clock),
            .reset          (reset),
            .req0_valid     (rq_v[i][0]),
            .req0_ready     (rq_r[i][0]),
            .req0_rs1       (rq_a[i][0]),
            .req0_rs2       (rq_b[i][0]),
            .req0_insn14    (rq_x[i][0]),
            .req1_valid     (rq_v[i][1]),
            .req1_ready     (rq_r[i][1]),
            .req1_rs1       (rq_a[i][1]),
            .req1_rs2       (rq_b[i][1]),
            .req1_insn14    (rq_x[i][1]),
            .rsp0_valid     (rs_v[i][0]),
            .rsp0_ready     (rs_r[i][0]),
            .rsp0_rd        (rs_d[i][0]),
            .rsp1_valid     (rs_v[i][1]),
            .rsp1_ready     (rs_r[i][1]),
            .rsp1_rd        (rs_d[i][1]),
            .core_din_valid (c_iv[i]),
            .core_din_ready (c_ir[i]),
            .core_din_rs1   (c_ia[i]),
            .core_din_rs2   (c_ib[i]),
            .core_din_insn14(c_ix[i]),
            .core_dout_valid(c_ov[i]),
            .core_dout_ready(c_or[i]),
            .core_dout_rd   (c_od[i]),
            .busy           (busy[i]),
            .op_count       (opc[i])
        );
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (inst %0d, t=%0t): got %h, expected %h", nm, act, $time, got, exp);
        end
    endtask

    // Transaction-level model: at most one op per instance, owner, last-served port, count.
    bit          m_busy [2];
    bit          m_own  [2];
    bit          m_last [2];
    bit          m_seen [2];
    int          m_k    [2];
    logic [63:0] m_a    [2];
    logic [63:0] m_b    [2];
    bit          m_x    [2];
    logic [15:0] m_cnt  [2];
    int          lit_own_n;
    int          lit_rd_n;
    int          lit_opc_n;
    int          frc_seen;
    int          cyc;

    always @(negedge clock) begin
        bit w;
        int act_p;
        cyc++;
        if (cyc == 3) begin
            chk("model_identity", bmat(64'h0123456789abcdef, 64'h0102040810204080, 1'b1), 64'h0123456789abcdef);
            chk("model_or_ones", bmat(64'hffffffffffffffff, 64'hffffffffffffffff, 1'b0), 64'hffffffffffffffff);
            chk("model_xor_ones", bmat(64'hffffffffffffffff, 64'hffffffffffffffff, 1'b1), 64'h0);
        end
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                chk("rst_req_ready", 64'({rq_r[i][1], rq_r[i][0]}), 64'd0);
                chk("rst_rsp_valid", 64'({rs_v[i][1], rs_v[i][0]}), 64'd0);
                chk("rst_core_hs", 64'({c_iv[i], c_or[i]}), 64'd0);
                chk("rst_busy", 64'(busy[i]), 64'd0);
                chk("rst_op_count", 64'(opc[i]), 64'd0);
                m_busy[i] = 1'b0;
                m_last[i] = 1'b1;
                m_cnt[i]  = 16'd0;
            end else begin
                if (frc_n != frc_seen && i == act) begin
                    m_cnt[i] = 16'hffff;
                    frc_seen = frc_n;
                end
                chk("op_count", 64'(opc[i]), 64'(m_cnt[i]));
                if (c_ov[i]) chk("core_dout_protocol", 64'(c_or[i]), 64'd1);
                if (!m_busy[i]) begin
                    chk("idle_busy", 64'(busy[i]), 64'd0);
                    chk("idle_rsp_valid", 64'({rs_v[i][1], rs_v[i][0]}), 64'd0);
                    chk("idle_core_hs", 64'({c_iv[i], c_or[i]}), 64'd0);
                    if (rq_v[i][0] || rq_v[i][1]) begin
                        if (rq_v[i][0] && rq_v[i][1]) w = (i == 0) ? !m_last[i] : 1'b0;
                        else w = rq_v[i][1];
                        chk("req_ready", 64'({rq_r[i][1], rq_r[i][0]}), w ? 64'd2 : 64'd1);
                        act_p = (rq_v[i][1] && rq_r[i][1]) ? 1 : ((rq_v[i][0] && rq_r[i][0]) ? 0 : -1);
                        if (i == act && lit_own_n < lit_own_q.size()) begin
                            chk("grant_order", 64'(act_p), 64'(lit_own_q[lit_own_n]));
                            lit_own_n++;
                        end
                        m_busy[i] = 1'b1;
                        m_own[i]  = w;
                        m_a[i]    = rq_a[i][w];
                        m_b[i]    = rq_b[i][w];
                        m_x[i]    = rq_x[i][w];
                        m_k[i]    = 0;
                        m_seen[i] = 1'b0;
                    end
                end else begin
                    m_k[i]++;
                    chk("busy", 64'(busy[i]), 64'd1);
                    chk("busy_req_ready", 64'({rq_r[i][1], rq_r[i][0]}), 64'd0);
                    chk("other_rsp_valid", 64'(rs_v[i][~m_own[i]]), 64'd0);
                    if (c_iv[i] && c_ir[i]) begin
                        chk("core_rs1", c_ia[i], m_a[i]);
                        chk("core_rs2", c_ib[i], m_b[i]);
                        chk("core_insn14", 64'(c_ix[i]), 64'(m_x[i]));
                    end
                    if (chk_lat && i == act)
                        chk("rsp_latency", 64'(rs_v[i][m_own[i]]), 64'(m_k[i] >= lat_exp));
                    if (m_seen[i]) chk("rsp_valid_held", 64'(rs_v[i][m_own[i]]), 64'd1);
                    if (rs_v[i][m_own[i]]) begin
                        m_seen[i] = 1'b1;
                        chk("rsp_rd", rs_d[i][m_own[i]], bmat(m_a[i], m_b[i], m_x[i]));
                        if (rs_r[i][m_own[i]]) begin
                            if (i == act && lit_rd_n < lit_rd_q.size()) begin
                                chk("rsp_rd_literal", rs_d[i][m_own[i]], lit_rd_q[lit_rd_n]);
                                lit_rd_n++;
                            end
                            m_busy[i] = 1'b0;
                            m_last[i] = m_own[i];
                            m_cnt[i]  = m_cnt[i] + 16'd1;
                        end
                    end else if (m_k[i] > 400) begin
                        chk("rsp_timeout", 64'(rs_v[i][m_own[i]]), 64'd1);
                        m_busy[i] = 1'b0;
                    end
                end
            end
        end
        if (lit_opc_n < lit_opc_q.size()) begin
            chk("op_count_literal", 64'(opc[act]), 64'(lit_opc_q[lit_opc_n]));
            lit_opc_n++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wait_grant(output int p);
        p = -1;
        for (int k = 0; k < 400 && p < 0; k++) begin
            @(negedge clock);
            if (rq_v[act][0] && rq_r[act][0]) p = 0;
            else if (rq_v[act][1] && rq_r[act][1]) p = 1;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 400; k++) begin
            @(negedge clock);
            if (!busy[act]) break;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic send(input int p, input logic [63:0] a, input logic [63:0] b, input logic x);
        int q;
        rq_a[act][p] = a;
        rq_b[act][p] = b;
        rq_x[act][p] = x;
        rq_v[act][p] = 1'b1;
        wait_grant(q);
        rq_v[act][p] = 1'b0;
    endtask

    task automatic hold_both(input int n);
        int p;
        for (int k = 0; k < 2; k++) begin
            rq_a[act][k] = {$urandom, $urandom};
            rq_b[act][k] = {$urandom, $urandom};
            rq_x[act][k] = 1'($urandom % 2);
            rq_v[act][k] = 1'b1;
        end
        for (int j = 0; j < n; j++) begin
            wait_grant(p);
            if (p >= 0) begin
                rq_a[act][p] = {$urandom, $urandom};
                rq_b[act][p] = {$urandom, $urandom};
                rq_x[act][p] = 1'($urandom % 2);
            end
        end
    endtask

    task automatic random_run(input int inst, input int cyc_sel, input int n);
        bit hs [2];
        act      = inst;
        core_cyc = cyc_sel;
        chk_lat  = 1'b0;
        for (int c = 0; c < n; c++) begin
            @(negedge clock);
            for (int p = 0; p < 2; p++) hs[p] = rq_v[act][p] && rq_r[act][p];
            @(posedge clock);
            #1;
            for (int p = 0; p < 2; p++) begin
                if (hs[p] || !rq_v[act][p]) begin
                    rq_v[act][p] = ($urandom % 3) != 0;
                    rq_a[act][p] = {$urandom, $urandom};
                    rq_b[act][p] = {$urandom, $urandom};
                    rq_x[act][p] = 1'($urandom % 2);
                end
                rs_r[act][p] = 1'($urandom % 2);
            end
            rdy_en[act] = ($urandom % 4) != 0;
        end
        rq_v[act][0] = 1'b0;
        rq_v[act][1] = 1'b0;
        rs_r[act][0] = 1'b1;
        rs_r[act][1] = 1'b1;
        rdy_en[act]  = 1'b1;
        wait_idle();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int p;
        n_chk = 0; n_fail = 0; cyc = 0;
        lit_own_n = 0; lit_rd_n = 0; lit_opc_n = 0; frc_n = 0; frc_seen = 0;
        act = 0; core_cyc = 0; chk_lat = 1'b0; lat_exp = 2;
        for (int i = 0; i < 2; i++) begin
            rdy_en[i] = 1'b1;
            m_busy[i] = 1'b0; m_last[i] = 1'b1; m_cnt[i] = 16'd0;
            for (int k = 0; k < 2; k++) begin
                rq_v[i][k] = 1'b0; rq_a[i][k] = '0; rq_b[i][k] = '0; rq_x[i][k] = 1'b0;
                rs_r[i][k] = 1'b1;
            end
        end
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(2);

        // Single XOR with the identity matrix, combinational core
        chk_lat = 1'b1; lat_exp = 2;
        lit_own_q.push_back(0);
        lit_rd_q.push_back(64'h0123456789abcdef);
        send(0, 64'h0123456789abcdef, 64'h0102040810204080, 1'b1);
        wait_idle();
        lit_opc_q.push_back(16'd1);

        // OR then XOR of all-ones on port 1, 8-cycle core
        core_cyc = 8; lat_exp = 11;
        lit_own_q.push_back(1);
        lit_rd_q.push_back(64'hffffffffffffffff);
        send(1, 64'hffffffffffffffff, 64'hffffffffffffffff, 1'b0);
        wait_idle();
        lit_own_q.push_back(1);
        lit_rd_q.push_back(64'h0);
        send(1, 64'hffffffffffffffff, 64'hffffffffffffffff, 1'b1);
        wait_idle();

        // Round-robin tie
        core_cyc = 0; lat_exp = 2;
        for (int k = 0; k < 4; k++) lit_own_q.push_back(k % 2);
        hold_both(4);
        rq_v[0][0] = 1'b0; rq_v[0][1] = 1'b0;
        wait_idle();

        // Backpressure on rsp0 while port 1 waits
        rs_r[0][0] = 1'b0;
        lit_own_q.push_back(0);
        send(0, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
        rq_a[0][1] = {$urandom, $urandom}; rq_b[0][1] = {$urandom, $urandom}; rq_x[0][1] = 1'b0;
        rq_v[0][1] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (rs_v[0][0]) break;
        end
        tick(5);
        rs_r[0][0] = 1'b1;
        lit_own_q.push_back(1);
        wait_grant(p);
        rq_v[0][1] = 1'b0;
        wait_idle();

        // Fixed-priority tie on the second instance
        act = 1;
        for (int k = 0; k < 4; k++) lit_own_q.push_back(0);
        lit_own_q.push_back(1);
        hold_both(4);
        rq_v[1][0] = 1'b0;
        wait_grant(p);
        rq_v[1][1] = 1'b0;
        wait_idle();

        // Reset while waiting on the 8-cycle core
        act = 0; core_cyc = 8; lat_exp = 11;
        send(0, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
        tick(4);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        lit_opc_q.push_back(16'd0);
        tick(1);
        lit_own_q.push_back(0);
        lit_rd_q.push_back(64'h0123456789abcdef);
        send(0, 64'h0123456789abcdef, 64'h0102040810204080, 1'b1);
        wait_idle();
        lit_opc_q.push_back(16'd1);

        // op_count wrap
        core_cyc = 0; lat_exp = 2;
        tick(1);
        frc_n = frc_n + 1;
        force g_inst[0].u_dut.op_count = 16'hffff;
        tick(1);
        release g_inst[0].u_dut.op_count;
        lit_opc_q.push_back(16'hffff);
        tick(1);
        send(1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
        wait_idle();
        lit_opc_q.push_back(16'h0000);
        tick(1);

        // Randomised traffic on both instances and both core latencies
        random_run(0, 0, 250);
        random_run(0, 8, 250);
        random_run(1, 0, 250);
        random_run(1, 8, 250);

        tick(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
